// File: rtl/mux_nx1_scan.sv
// Registered N:1 multiplexer with static select and round-robin auto-scan.
// Scan mode holds each channel for dwell+1 enabled cycles and pulses wrap on return to channel 0.
module mux_nx1_scan #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      en,
  output logic [WIDTH-1:0]          result,
  output logic                      result_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int               NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0]   NCH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]   ch;
  logic [DWELL_W-1:0] dc;
  logic               pm;

  logic [WIDTH-1:0]   chan [NSLOT];
  logic               sel_ok;
  logic [SEL_W-1:0]   ent_sel;
  logic [SEL_W-1:0]   nxt_ch;
  logic               adv;

  // Unused select codes (non power-of-two CHANNELS) read as zero data.
  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < CHANNELS) begin : g_on
      assign chan[k] = d[k*WIDTH +: WIDTH];
    end else begin : g_off
      assign chan[k] = '0;
    end
  end

  always_comb begin
    sel_ok  = ({1'b0, sel} < NCH);
    ent_sel = sel_ok ? sel : '0;
    nxt_ch  = (ch == LAST) ? '0 : ch + SEL_W'(1);
    // >= so a dwell lowered below the running count advances on the next edge.
    adv     = (dc >= dwell);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      cur_sel      <= '0;
      wrap         <= 1'b0;
      sel_err      <= 1'b0;
      ch           <= '0;
      dc           <= '0;
      pm           <= 1'b0;
    end else if (!en) begin
      result_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      result_valid <= 1'b1;
      pm           <= mode;
      wrap         <= 1'b0;
      if (!mode) begin
        cur_sel <= sel;
        result  <= chan[sel];
        sel_err <= ~sel_ok;
        ch      <= sel;
        dc      <= '0;
      end else if (!pm) begin
        ch      <= ent_sel;
        cur_sel <= ent_sel;
        result  <= chan[ent_sel];
        sel_err <= ~sel_ok;
        dc      <= '0;
      end else if (adv) begin
        ch      <= nxt_ch;
        cur_sel <= nxt_ch;
        result  <= chan[nxt_ch];
        dc      <= '0;
        wrap    <= (ch == LAST);
      end else begin
        dc      <= dc + DWELL_W'(1);
        cur_sel <= ch;
        result  <= chan[ch];
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: a 4x1-bit and a 3x8-bit instance run side by side
// against a behavioural model, with directed scenarios followed by random traffic.
module tb_mux_nx1_scan;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  da;
  logic [1:0]  sela;
  logic        modea, ena;
  logic [7:0]  dwella;
  logic        resa, rva, wrapa, erra;
  logic [1:0]  csa;

  logic [23:0] db;
  logic [1:0]  selb;
  logic        modeb, enb;
  logic [7:0]  dwellb;
  logic [7:0]  resb;
  logic        rvb, wrapb, errb;
  logic [1:0]  csb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_nx1_scan #(.CHANNELS(4), .WIDTH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .d(da), .sel(sela), .mode(modea), .dwell(dwella),
    .en(ena), .result(resa), .result_valid(rva), .cur_sel(csa), .wrap(wrapa),
    .sel_err(erra)
  );

  mux_nx1_scan #(.CHANNELS(3), .WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .d(db), .sel(selb), .mode(modeb), .dwell(dwellb),
    .en(enb), .result(resb), .result_valid(rvb), .cur_sel(csb), .wrap(wrapb),
    .sel_err(errb)
  );

  typedef struct {
    int ch; int dc; int pm; int res; int rv; int cs; int wrap; int err;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mreset();
    mstate_t z;
    z = '{default: 0};
    return z;
  endfunction

  // One enabled/disabled edge of the described behaviour, in plain integers.
  function automatic mstate_t mstep(mstate_t s, int nch, int dat[4], int sel,
                                    int mode, int dwell, int en);
    mstate_t n;
    int c;
    n = s;
    if (en == 0) begin
      n.rv = 0; n.wrap = 0;
      return n;
    end
    n.rv = 1; n.wrap = 0; n.pm = mode;
    if (mode == 0) begin
      n.cs = sel; n.ch = sel; n.dc = 0;
      n.err = (sel >= nch) ? 1 : 0;
      n.res = (sel < nch) ? dat[sel] : 0;
    end else if (s.pm == 0) begin
      c = (sel < nch) ? sel : 0;
      n.ch = c; n.cs = c; n.dc = 0; n.res = dat[c];
      n.err = (sel >= nch) ? 1 : 0;
    end else if (s.dc >= dwell) begin
      c = (s.ch + 1) % nch;
      n.ch = c; n.cs = c; n.dc = 0; n.res = dat[c];
      n.wrap = (c == 0) ? 1 : 0;
    end else begin
      n.dc = s.dc + 1; n.cs = s.ch; n.res = dat[s.ch];
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    chk("A.result", 32'(resa), ma.res);
    chk("A.valid", 32'(rva), ma.rv);
    chk("A.cur_sel", 32'(csa), ma.cs);
    chk("A.wrap", 32'(wrapa), ma.wrap);
    chk("A.sel_err", 32'(erra), ma.err);
    chk("B.result", 32'(resb), mb.res);
    chk("B.valid", 32'(rvb), mb.rv);
    chk("B.cur_sel", 32'(csb), mb.cs);
    chk("B.wrap", 32'(wrapb), mb.wrap);
    chk("B.sel_err", 32'(errb), mb.err);
  endtask

  task automatic tick();
    int dA[4];
    int dB[4];
    mstate_t nA, nB;
    for (int k = 0; k < 4; k++) dA[k] = int'(da[k]);
    for (int k = 0; k < 3; k++) dB[k] = int'(db[k*8 +: 8]);
    dB[3] = 0;
    nA = mstep(ma, 4, dA, int'(sela), int'(modea), int'(dwella), int'(ena));
    nB = mstep(mb, 3, dB, int'(selb), int'(modeb), int'(dwellb), int'(enb));
    @(posedge clk);
    ma = nA;
    mb = nB;
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    rst_n = 1'b0;
    #2;
    ma = mreset();
    mb = mreset();
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_cs2 [10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int exp_rs2 [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int exp_rs3 [4]  = '{8'h11, 8'h22, 8'h33, 8'h11};

    rst_n = 1'b0;
    da = '0; sela = '0; modea = 1'b0; ena = 1'b0; dwella = '0;
    db = '0; selb = '0; modeb = 1'b0; enb = 1'b0; dwellb = '0;
    ma = mreset();
    mb = mreset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Static sweep of every {sel, d}; B runs static with random selects including 3.
    ena = 1'b1; enb = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 16; v++) begin
        sela = 2'(s); da = 4'(v);
        selb = 2'($urandom_range(3)); db = 24'($urandom);
        tick();
        chk("T1.static_result", 32'(resa), (v >> s) & 1);
      end
    end
    mid_reset();

    // A: scan dwell=2 from channel 1; B: scan dwell=0 over 11/22/33.
    ena = 1'b1; enb = 1'b1;
    modea = 1'b1; dwella = 8'd2; sela = 2'd1; da = 4'b1010;
    modeb = 1'b1; dwellb = 8'd0; selb = 2'd0; db = {8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("T2.cur_sel", 32'(csa), exp_cs2[i]);
      chk("T2.result", 32'(resa), exp_rs2[i]);
      chk("T2.wrap", 32'(wrapa), (i == 9) ? 1 : 0);
      if (i < 4) chk("T3.result", 32'(resb), exp_rs3[i]);
      chk("T3.wrap", 32'(wrapb), (i % 3 == 0 && i > 0) ? 1 : 0);
    end

    // En gating mid-dwell.
    dwella = 8'd1; dwellb = 8'd1;
    tick(); tick(); tick();
    ena = 1'b0; enb = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ena = 1'b1; enb = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Bad select on the 3-channel instance.
    modeb = 1'b0; selb = 2'd3; db = {8'hc3, 8'hb2, 8'ha1};
    tick();
    chk("T5.bad_static_result", 32'(resb), 0);
    chk("T5.bad_static_err", 32'(errb), 1);
    modeb = 1'b1;
    tick();
    chk("T5.scan_clamp_sel", 32'(csb), 0);
    chk("T5.scan_clamp_err", 32'(errb), 1);
    modeb = 1'b0; selb = 2'd2;
    tick();
    chk("T5.recover_err", 32'(errb), 0);
    chk("T5.recover_result", 32'(resb), 8'hc3);

    // Mode switch mid-scan, then reset mid-scan and restart.
    modea = 1'b1; sela = 2'd1; dwella = 8'd2; da = 4'b0110;
    for (int i = 0; i < 5; i++) tick();
    modea = 1'b0; sela = 2'd0;
    tick();
    chk("T6.exit_cur_sel", 32'(csa), 0);
    chk("T6.exit_wrap", 32'(wrapa), 0);
    modea = 1'b1; sela = 2'd2;
    tick(); tick();
    mid_reset();
    tick();
    chk("T6.restart_cur_sel", 32'(csa), 2);

    // Random traffic, including dwell changes below the running count.
    for (int i = 0; i < 600; i++) begin
      da = 4'($urandom);
      db = 24'($urandom);
      ena = ($urandom_range(9) < 8);
      enb = ($urandom_range(9) < 8);
      if ($urandom_range(15) == 0) modea = ~modea;
      if ($urandom_range(15) == 0) modeb = ~modeb;
      if ($urandom_range(7) == 0) sela = 2'($urandom);
      if ($urandom_range(7) == 0) selb = 2'($urandom);
      if ($urandom_range(5) == 0) dwella = 8'($urandom_range(4));
      if ($urandom_range(5) == 0) dwellb = 8'($urandom_range(4));
      tick();
      if ($urandom_range(99) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
